// File: rtl/dual_port_ram_scanner.sv
// DATA_W x 2**ADDR_W RAM with a handshaked write port, a host read port and an
// autonomous LED scanner; the array is zeroed after every reset before traffic is accepted.
module dual_port_ram_scanner #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DWELL  = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] leds,
  output logic              busy
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clear_addr_q, clear_addr_d;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_d;
  logic [ADDR_W-1:0]   scan_addr_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [ADDR_W-1:0]   ram_raddr;
  logic                host_rd;
  logic                scan_rd;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state, RAM port steering and scanner advance
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    dwell_d      = dwell_cnt;
    scan_addr_d  = scan_addr;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    ram_raddr    = scan_addr;
    host_rd      = 1'b0;
    scan_rd      = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clear_addr_q;
        mem_wdata    = '0;
        clear_addr_d = clear_addr_q + 1'b1;
        if (clear_addr_q == ADDR_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        mem_we  = wr_valid && wr_ready;
        // Host owns the single read port when it asks; the scanner fills idle cycles
        host_rd = rd_req;
        scan_rd = !rd_req;
        if (rd_req) begin
          ram_raddr = rd_addr;
        end
        if (scan_en) begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_d     = '0;
            scan_addr_d = scan_addr + 1'b1;
          end else begin
            dwell_d = dwell_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Control state, registered outputs and read-first data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clear_addr_q <= '0;
      dwell_cnt    <= '0;
      scan_addr    <= '0;
      wr_ready     <= 1'b0;
      busy         <= 1'b1;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      leds         <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      dwell_cnt    <= dwell_d;
      scan_addr    <= scan_addr_d;
      wr_ready     <= (state_d == ST_RUN);
      busy         <= (state_d == ST_CLEAR);
      rd_valid     <= host_rd;
      if (host_rd) begin
        rd_data <= mem[ram_raddr];
      end
      if (scan_rd) begin
        leds <= mem[ram_raddr];
      end
    end
  end

  // RAM array carries no reset; the CLEAR walk initialises it
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_scanner.sv
// Bench for dual_port_ram_scanner: vector table plus read scoreboard and a
// scanner reference model for the LED path.
module tb_dual_port_ram_scanner;

  localparam int unsigned DATA_W = 10;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DWELL  = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              scan_en = 1'b0;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] leds;
  logic              busy;

  always #5 clk = ~clk;

  dual_port_ram_scanner #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DWELL (DWELL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .scan_en  (scan_en),
    .scan_addr(scan_addr),
    .leds     (leds),
    .busy     (busy)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t              vecs [6];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] rd_q [$];
  int                n_chk  = 0;
  int                n_fail = 0;
  logic [ADDR_W-1:0] exp_scan;
  int                exp_dwell;
  logic [DATA_W-1:0] exp_leds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every rd_valid must match the oldest outstanding host read
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (rd_q.size() == 0) check("rd_valid_unexpected", 32'(rd_valid), 32'(0));
      else check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Reference for the scanner; call right after a posedge
  task automatic scan_step(input bit host);
    if (!host) exp_leds = model[exp_scan];
    if (scan_en) begin
      if (exp_dwell == int'(DWELL) - 1) begin
        exp_dwell = 0;
        exp_scan  = exp_scan + 1'b1;
      end else begin
        exp_dwell++;
      end
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    check("wr_ready_run", 32'(wr_ready), 32'(1));
    @(posedge clk);
    model[a] = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    rd_req  = 1'b1;
    rd_addr = a;
    rd_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
    check("reads_drained", 32'(rd_q.size()), 32'(0));
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      check("wr_ready_clear", 32'(wr_ready), 32'(0));
      cnt++;
      @(posedge clk);
      @(negedge clk);
      rd_req = 1'b0;
    end
    check(name, 32'(cnt), 32'(16));
    check("wr_ready_after_clear", 32'(wr_ready), 32'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_wr_ready",  32'(wr_ready),  32'(0));
    check("rst_rd_valid",  32'(rd_valid),  32'(0));
    check("rst_rd_data",   32'(rd_data),   32'(0));
    check("rst_leds",      32'(leds),      32'(0));
    check("rst_scan_addr", 32'(scan_addr), 32'(0));
    check("rst_busy",      32'(busy),      32'(1));
  endtask

  initial begin
    vecs[0] = '{addr: 4'd1,  wdata: 10'h3FF, exp: 10'h3FF};
    vecs[1] = '{addr: 4'd15, wdata: 10'h000, exp: 10'h000};
    vecs[2] = '{addr: 4'd7,  wdata: 10'h2AA, exp: 10'h2AA};
    vecs[3] = '{addr: 4'd8,  wdata: 10'h155, exp: 10'h155};
    vecs[4] = '{addr: 4'd0,  wdata: 10'h001, exp: 10'h001};
    vecs[5] = '{addr: 4'd15, wdata: 10'h200, exp: 10'h200};
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // Reset values while held
    repeat (2) @(negedge clk);
    check_reset_outputs();

    // Release with a write and a read pending during CLEAR
    rst      = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 4'd2;
    wr_data  = 10'h3FF;
    rd_req   = 1'b1;
    rd_addr  = 4'd2;
    wait_clear("clear_cycles");
    @(posedge clk);
    model[2] = 10'h3FF;
    @(negedge clk);
    wr_valid = 1'b0;
    host_read(4'd2, 10'h3FF);

    // Back-to-back reads of the whole array
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(i);
      rd_q.push_back(model[i]);
      @(posedge clk);
      @(negedge clk);
    end
    rd_req = 1'b0;
    drain();

    // Same-cycle write and read of one address returns the old word
    wr_valid = 1'b1;
    wr_addr  = 4'd5;
    wr_data  = 10'h155;
    rd_req   = 1'b1;
    rd_addr  = 4'd5;
    rd_q.push_back(model[5]);
    @(posedge clk);
    model[5] = 10'h155;
    @(negedge clk);
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    host_read(4'd5, 10'h155);
    drain();

    // Table of write/read-back vectors
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata);
      host_read(vecs[i].addr, vecs[i].exp);
    end
    drain();

    // Fill mem[i] = i+1, then scan with wrap
    for (int i = 0; i < int'(DEPTH); i++) do_write(ADDR_W'(i), DATA_W'(i + 1));
    @(posedge clk);
    @(negedge clk);
    check("leds_pre_scan", 32'(leds), 32'(model[0]));
    exp_scan  = '0;
    exp_dwell = 0;
    exp_leds  = model[0];
    scan_en   = 1'b1;
    for (int k = 0; k < 68; k++) begin
      @(posedge clk);
      scan_step(1'b0);
      @(negedge clk);
      check("scan_addr", 32'(scan_addr), 32'(exp_scan));
      check("scan_leds", 32'(leds), 32'(exp_leds));
    end

    // Freeze
    scan_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      scan_step(1'b0);
      @(negedge clk);
      check("frozen_scan_addr", 32'(scan_addr), 32'(exp_scan));
      check("frozen_leds", 32'(leds), 32'(exp_leds));
    end

    // Host read burst during scanning
    scan_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k < 10) begin
        rd_req  = 1'b1;
        rd_addr = ADDR_W'(k * 3);
        rd_q.push_back(model[(k * 3) % int'(DEPTH)]);
      end else begin
        rd_req = 1'b0;
      end
      @(posedge clk);
      scan_step(k < 10);
      @(negedge clk);
      check("burst_scan_addr", 32'(scan_addr), 32'(exp_scan));
      check("burst_leds", 32'(leds), 32'(exp_leds));
    end
    drain();

    // Asynchronous reset mid-scan
    check("leds_nonzero_before_rst", 32'(leds != '0), 32'(1));
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    scan_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    rst = 1'b0;
    wait_clear("clear_cycles_after_rst");
    check("leds_after_clear", 32'(leds), 32'(0));
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_req  = 1'b1;
      rd_addr = ADDR_W'(i);
      rd_q.push_back(model[i]);
      @(posedge clk);
      @(negedge clk);
    end
    rd_req = 1'b0;
    drain();
    check("leds_idle_after_clear", 32'(leds), 32'(0));
    check("scan_addr_after_clear", 32'(scan_addr), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
